// File: rtl/modexp_l2r.sv
// Modular left-to-right square-and-multiply exponentiator: C = A^E mod M.
// Leading exponent zeros are skipped; each modular product is formed bit-serially, one bit per cycle.
module modexp_l2r #(
  parameter int W  = 16,
  parameter int EW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  A,
  input  logic [EW-1:0] E,
  input  logic [W-1:0]  M,
  output logic [W-1:0]  C,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int IW = (EW > 1) ? $clog2(EW) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(EW - 1);
  localparam logic [JW-1:0] J_TOP = JW'(W - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_SQR  = 3'd3;
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state;
  logic [W-1:0]  a_r;
  logic [EW-1:0] e_r;
  logic [W-1:0]  m_r;
  logic [W-1:0]  r_r;
  logic [W+1:0]  p_r;
  logic [IW-1:0] i_r;
  logic [JW-1:0] j_r;

  // One step of the interleaved multiplier; R is always the X operand.
  logic          y_bit;
  logic [W+1:0]  m_ext;
  logic [W+1:0]  x_ext;
  logic [W+1:0]  p_dbl;
  logic [W+1:0]  p_add;
  logic [W+1:0]  p_red1;
  logic [W+1:0]  p_red2;
  logic          op_last;
  logic          bit_set;
  logic          i_zero;
  logic          bad_operands;

  // NOTE: every signal assigned in always_comb gets a default on entry so no latch is inferred.
  always_comb begin
    y_bit  = 1'b0;
    m_ext  = {2'b00, m_r};
    x_ext  = {2'b00, r_r};
    p_dbl  = p_r << 1;
    if (state == S_MUL) y_bit = a_r[j_r];
    else                y_bit = r_r[j_r];
    p_add  = p_dbl + (y_bit ? x_ext : '0);
    p_red1 = (p_add >= m_ext) ? (p_add - m_ext) : p_add;
    p_red2 = (p_red1 >= m_ext) ? (p_red1 - m_ext) : p_red1;
  end

  assign op_last      = (j_r == '0);
  assign bit_set      = e_r[i_r];
  assign i_zero       = (i_r == '0);
  assign bad_operands = (m_r == '0) || (a_r >= m_r);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // NOTE: all state, including operand and working registers, is cleared by the async reset
  // so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      e_r   <= '0;
      m_r   <= '0;
      r_r   <= '0;
      p_r   <= '0;
      i_r   <= '0;
      j_r   <= '0;
      C     <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= A;
            e_r   <= E;
            m_r   <= M;
            err   <= 1'b0;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bad_operands) begin
            C     <= '0;
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            r_r   <= (m_r == W'(1)) ? '0 : W'(1);
            i_r   <= I_TOP;
            state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (bit_set) begin
            // The leading one only needs R*A; squaring 1 would be wasted work.
            p_r   <= '0;
            j_r   <= J_TOP;
            state <= S_MUL;
          end else if (i_zero) begin
            C     <= r_r;
            state <= S_DONE;
          end else begin
            i_r <= i_r - IW'(1);
          end
        end

        S_SQR, S_MUL: begin
          if (!op_last) begin
            p_r <= p_red2;
            j_r <= j_r - JW'(1);
          end else begin
            r_r <= p_red2[W-1:0];
            p_r <= '0;
            j_r <= J_TOP;
            if (state == S_SQR && bit_set) begin
              state <= S_MUL;
            end else if (i_zero) begin
              C     <= p_red2[W-1:0];
              state <= S_DONE;
            end else begin
              i_r   <= i_r - IW'(1);
              state <= S_SQR;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_l2r.sv
// Directed bench for modexp_l2r at W=8, EW=8: result, err flag, done latency and busy window
// per vector, plus ignored-start, back-to-back and mid-run reset sequences.
module tb_modexp_l2r;

  localparam int W  = 8;
  localparam int EW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [EW-1:0] e;
  logic [W-1:0]  m;
  logic [W-1:0]  c;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks;
  int n_errors;

  modexp_l2r #(.W(W), .EW(EW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .E     (e),
    .M     (m),
    .C     (c),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [EW-1:0] e;
    logic [W-1:0]  m;
    logic [W-1:0]  c;
    logic          err;
    int            cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start sampled in cycle 0; done is expected in cycle v.cyc. When ign_cyc > 0 a second
  // start with different operands is driven during that busy cycle.
  task automatic run(input string tag, input vec_t v, input int ign_cyc);
    int cyc;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " idle_done"}, done, 0);
    a = v.a; e = v.e; m = v.m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; seen = 0; busy_ok = 1;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) begin
        seen = 1;
      end else begin
        if (cyc == ign_cyc) begin
          a = 8'd2; e = 8'd10; m = 8'd255; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " done_cycle"}, cyc, v.cyc);
    check({tag, " result"}, c, v.c);
    check({tag, " err"}, err, v.err);
    check({tag, " busy_window"}, busy_ok, 1);
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_errors = 0;

    //             a       e       m       c       err   done cycle
    vecs[0]  = '{8'd3,   8'd5,   8'd7,   8'd5,   1'b0, 40};
    vecs[1]  = '{8'd2,   8'd10,  8'd255, 8'd4,   1'b0, 47};
    vecs[2]  = '{8'd6,   8'd0,   8'd13,  8'd1,   1'b0, 10};
    vecs[3]  = '{8'd0,   8'd3,   8'd1,   8'd0,   1'b0, 33};
    vecs[4]  = '{8'd9,   8'd5,   8'd7,   8'd0,   1'b1, 2};
    vecs[5]  = '{8'd7,   8'd2,   8'd10,  8'd9,   1'b0, 25};
    vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b1, 2};
    vecs[7]  = '{8'd254, 8'd255, 8'd255, 8'd254, 1'b0, 123};
    vecs[8]  = '{8'd5,   8'd128, 8'd251, 8'd125, 1'b0, 67};
    vecs[9]  = '{8'd1,   8'd1,   8'd2,   8'd1,   1'b0, 18};
    vecs[10] = '{8'd0,   8'd0,   8'd1,   8'd0,   1'b0, 10};

    rst = 1'b0; start = 1'b0; a = '0; e = '0; m = '0;
    repeat (2) @(negedge clk);
    check("reset C", c, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run($sformatf("v%0d", i), vecs[i], 0);

    // Start while busy must not disturb the captured operands; the next run starts
    // in the cycle right after DONE.
    run("ignored_start", vecs[0], 5);
    run("back_to_back", vecs[1], 0);

    // Reset in the middle of the first squaring (cycles 16..23 for 3^5 mod 7).
    @(negedge clk);
    a = 8'd3; e = 8'd5; m = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst C", c, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst err", err, 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("midrst no_done", done_cnt, 0);
    run("after_rst", vecs[0], 0);
    run("after_rst2", vecs[8], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modexp_l2r.md
Name: modexp_l2r

Overview:
- Parametrised modular left-to-right square-and-multiply exponentiator. Computes C = A^E mod M.
- Adds three things the plain L2R exponentiator lacks: modular reduction, separate base/exponent widths, and leading-zero skip.
- Adds a busy/done/err handshake so it can sit as a coprocessor behind a top-level controller.
- Control FSM and datapath live in one module. Multiplication uses a bit-serial interleaved modular multiplier, 1 bit per cycle.

Parameters:
- W, 16, width of A, M and C.
- EW, 16, width of exponent E.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only while busy=0.
- A  in  W  base. Captured on accepted start. Must be < M.
- E  in  EW  exponent. Captured on accepted start.
- M  in  W  modulus. Captured on accepted start. Must be ≥1.
- C  out  W  result register. Held until the next accepted start finishes.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when C is valid.
- err  out  1  set with done when A>=M or M==0. Held until next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; C=0, busy=0, done=0, err=0; internal registers cleared.
- Reset mid-operation aborts the computation. No done pulse is produced.
- States: IDLE, LOAD, SCAN, SQR, MUL, DONE.
- IDLE:
  - On start=1: capture A, E, M into internal registers; clear err; go to LOAD.
  - start while busy=1 is ignored; captured operands are unaffected.
- LOAD (1 cycle):
  - If M==0 or A>=M: C<=0, err<=1, go to DONE.
  - Otherwise: R<=1 mod M (0 if M==1, else 1); bit index i<=EW-1; go to SCAN.
- SCAN (1 cycle per bit examined):
  - If E[i]==1: go to MUL (no square for the leading one).
  - Else if i==0: go to DONE with C<=R (E==0 gives 1 mod M).
  - Else i<=i-1.
- SQR: R<=R*R mod M over W cycles.
- MUL: R<=R*A mod M over W cycles.
- After SQR: if E[i]==1 go to MUL; else if i==0 go to DONE; else i<=i-1, go to SQR.
- After MUL: if i==0 go to DONE; else i<=i-1, go to SQR.
- On every entry to DONE from SQR/MUL, C<=R.
- DONE (1 cycle): done=1, busy=1; next state IDLE. done never asserts in any other state.
- Modular multiply X*Y mod M (exactly W cycles): P=0; for j=W-1 down to 0: P=2P; if Y[j] then P+=X; if P>=M then P-=M; if P>=M then P-=M.
  - P is held W+2 bits wide internally; no overflow is permitted.
  - Operands are always < M, so P stays < M after every step.
- Latency (start sampled in cycle 0; z = number of leading zeros of E; L = bit length of E):
  - Error case: done in cycle 2.
  - E==0: done in cycle EW+2.
  - Otherwise: done in cycle z+3+W*((L-1)+popcount(E)).
- busy rises in cycle 1 and falls after the DONE cycle. A start in the cycle after DONE is accepted.

Test Plan:
- W=8, EW=8: A=3, E=5, M=7 -> C=5, err=0, done in cycle 40 (z=5, 4 ops), busy high cycles 1–40.
- A=2, E=10, M=255 -> C=4, done in cycle 3+4+8*(3+2)=47.
- E=0, M=13, A=6 -> C=1 at cycle 10. Then M=1, A=0, E=3 -> C=0, err=0.
- A=9, M=7 (and separately M=0) -> err=1, C=0, done in cycle 2. Next valid run clears err.
- start pulsed at cycle 5 of a run with different operands -> ignored; first result unchanged. Back-to-back start the cycle after done -> accepted.
- rst low mid-SQR -> C=0, busy=0, done=0 immediately, no done pulse. A run after rst release gives the correct result.
